// File: rtl/ip_tx.sv
// ip_tx: IPv4 encapsulation of the UDP transmit stream; the header checksum is computed before the upstream grant,
// and the UDP bytes pass through a 20-stage delay line so they follow the 20 header bytes without a gap.
module ip_tx #(
  parameter logic [31:0] LOCAL_IP = 32'hC0A8010A,
  parameter logic [7:0]  TTL      = 8'h80
) (
  input  logic        udp_send_clk,
  input  logic        rstn,
  input  logic [31:0] dest_ip,
  input  logic        udp_send_request,
  input  logic        udp_data_out_valid,
  input  logic [7:0]  udp_data_out,
  input  logic [15:0] udp_packet_length,
  output logic        ip_send_ready,
  output logic        ip_send_ack,
  input  logic        mac_send_ready,
  output logic        mac_send_request,
  output logic        ip_data_out_valid,
  output logic [7:0]  ip_data_out,
  output logic [15:0] ip_packet_length
);
  typedef enum logic [2:0] {IDLE, CHECKSUM, WAIT_MAC, READY, SEND_HEADER, SEND_PAYLOAD} state_t;
  state_t state, state_nxt;
  logic [15:0]  cnt, idx_nxt, ident, ident_q, csum;
  logic [31:0]  dest_q, sum;
  logic [16:0]  fold1, fold2;
  logic [7:0]   sr [20];
  logic [159:0] hdr, hdr_sh;
  logic [4:0]   sel;
  logic         last, shift;
  always_comb begin
    idx_nxt = cnt + 16'd1;
    last    = idx_nxt == ip_packet_length;
    shift   = (state == READY && udp_data_out_valid) || state == SEND_HEADER || state == SEND_PAYLOAD;
    fold1   = {1'b0, sum[15:0]} + {1'b0, sum[31:16]};
    fold2   = {1'b0, fold1[15:0]} + {16'd0, fold1[16]};
    hdr     = {8'h45, 8'h00, ip_packet_length, ident_q, 16'h4000, TTL, 8'h11, csum, LOCAL_IP, dest_q};
    sel     = state == READY ? 5'd0 : idx_nxt[4:0];
    hdr_sh  = hdr << {sel, 3'b000};
    state_nxt = state;
    case (state)
      IDLE:         state_nxt = udp_send_request ? CHECKSUM : IDLE;
      CHECKSUM:     state_nxt = cnt == 16'd2 ? WAIT_MAC : CHECKSUM;
      WAIT_MAC:     state_nxt = mac_send_ready ? READY : WAIT_MAC;
      READY:        state_nxt = udp_data_out_valid ? SEND_HEADER : READY;
      SEND_HEADER:  state_nxt = last ? IDLE : idx_nxt == 16'd20 ? SEND_PAYLOAD : SEND_HEADER;
      SEND_PAYLOAD: state_nxt = last ? IDLE : SEND_PAYLOAD;
      default:      state_nxt = IDLE;
    endcase
    mac_send_request  = state inside {WAIT_MAC, READY, SEND_HEADER, SEND_PAYLOAD};
    ip_send_ready     = state inside {READY, SEND_HEADER, SEND_PAYLOAD};
    ip_data_out_valid = state inside {SEND_HEADER, SEND_PAYLOAD};
  end
  always_ff @(posedge udp_send_clk)
    state <= !rstn ? IDLE : state_nxt;
  always_ff @(posedge udp_send_clk) begin
    if (!rstn) begin
      cnt              <= '0;
      ident            <= '0;
      ident_q          <= '0;
      csum             <= '0;
      dest_q           <= '0;
      sum              <= '0;
      ip_send_ack      <= 1'b0;
      ip_data_out      <= '0;
      ip_packet_length <= '0;
      for (int i = 0; i < 20; i++) sr[i] <= '0;
    end else begin
      ip_send_ack <= state == READY && udp_data_out_valid;
      if (shift) begin
        sr[0] <= udp_data_out;
        for (int i = 1; i < 20; i++) sr[i] <= sr[i-1];
      end
      case (state)
        IDLE: if (udp_send_request) cnt <= '0;
        CHECKSUM: begin
          cnt <= cnt + 16'd1;
          if (cnt == 16'd0) begin
            ip_packet_length <= udp_packet_length + 16'd20;
            dest_q           <= dest_ip;
            ident_q          <= ident;
          end
          if (cnt == 16'd1)
            sum <= 32'h4500 + 32'(ip_packet_length) + 32'(ident_q) + 32'h4000 + 32'({TTL, 8'h11})
                 + 32'(LOCAL_IP[31:16]) + 32'(LOCAL_IP[15:0]) + 32'(dest_q[31:16]) + 32'(dest_q[15:0]);
          if (cnt == 16'd2) csum <= ~fold2[15:0];
        end
        READY: if (udp_data_out_valid) begin
          cnt         <= '0;
          ip_data_out <= hdr_sh[159:152];
        end
        SEND_HEADER, SEND_PAYLOAD: begin
          if (last) begin
            ip_data_out <= '0;
            ident       <= ident + 16'd1;
          end else begin
            cnt         <= idx_nxt;
            ip_data_out <= idx_nxt < 16'd20 ? hdr_sh[159:152] : sr[19];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/ip_tx.md
# ip_tx

Transmit-side IPv4 encapsulation stage that sits directly downstream of the UDP transmit stage and upstream of the MAC transmit stage. It takes the UDP byte stream (UDP header plus payload) and the UDP length, and computes the IPv4 header checksum before granting the upstream handshake. It then emits a 20-byte IPv4 header followed by the UDP bytes, which are delayed through an internal 20-byte shift line so the output stream is continuous.

## Interface
- LOCAL_IP, 32'hC0A8010A, source IP address
- TTL, 8'h80, time-to-live field
- udp_send_clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- dest_ip  in  32  destination IP address, sampled at packet start
- udp_send_request  in  1  upstream packet request
- udp_data_out_valid  in  1  upstream byte valid
- udp_data_out  in  8  upstream byte (UDP header + payload)
- udp_packet_length  in  16  UDP length including the 8-byte UDP header
- ip_send_ready  out  1  grant to upstream; upstream begins its header only after seeing this high
- ip_send_ack  out  1  one-cycle pulse when the first upstream valid byte is accepted
- mac_send_ready  in  1  MAC stage able to accept a packet
- mac_send_request  out  1  packet request to MAC stage
- ip_data_out_valid  out  1  output byte valid
- ip_data_out  out  8  output byte
- ip_packet_length  out  16  IP total length = udp_packet_length + 20

## Operation
- States: IDLE, CHECKSUM, WAIT_MAC, READY, SEND_HEADER, SEND_PAYLOAD.
- IDLE:
  - on udp_send_request, go to CHECKSUM.
  - Requests arriving in any other state are ignored; a request held high is accepted on return to IDLE.
- CHECKSUM, exactly 3 cycles:
  - cycle 0 latches udp_packet_length, dest_ip and the current identification counter, and sets ip_packet_length = udp_packet_length + 16'd20 (16-bit modulo, no saturation).
  - cycle 1 forms a 32-bit sum of the ten header words with the checksum word set to 0: 16'h4500, total length, ident, 16'h4000 (DF), {TTL, 8'h11}, 0, LOCAL_IP[31:16], LOCAL_IP[15:0], dest_ip[31:16], dest_ip[15:0].
  - cycle 2 folds the carry twice and inverts the result to give the checksum.
  - Then go to WAIT_MAC.
- WAIT_MAC:
  - mac_send_request = 1, held until the packet ends.
  - When mac_send_ready = 1, go to READY.
- READY:
  - ip_send_ready = 1.
  - On the first cycle with udp_data_out_valid = 1: pulse ip_send_ack, go to SEND_HEADER, and start the byte counter at 0.
  - Valid bytes seen before READY are discarded.
- SEND_HEADER, 20 cycles: emit version/IHL, TOS, total length hi/lo, ident hi/lo, flags/fragment hi/lo, TTL, protocol 0x11, checksum hi/lo, source IP (4 bytes), destination IP (4 bytes).
- SEND_PAYLOAD:
  - emit the output of the delay line.
  - When the byte counter reaches ip_packet_length, drop valid and return to IDLE.
  - Increment the identification counter (16-bit, wraps 16'hFFFF→0).
- Delay line:
  - 20 stages, shifting every cycle from entry into SEND_HEADER until IDLE.
  - Termination is count-driven. If udp_data_out_valid drops early, whatever the line holds (zeros after valid drops) is still emitted.
  - udp_data_out is captured regardless of valid while shifting.
- ip_send_ready = 1 in READY, SEND_HEADER and SEND_PAYLOAD; 0 otherwise.

## Timing
- Reset values: all outputs 0; ip_packet_length 0; identification counter 0; state IDLE; delay line cleared.
- Reset mid-packet: outputs drop to 0 on the next edge; no partial trailer is emitted.
- Request to mac_send_request: request high at cycle R gives CHECKSUM at R+1..R+3 and mac_send_request high from R+4.
- First upstream valid byte at cycle T (in READY): ip_send_ack is high during T+1; header byte 0 is on ip_data_out at T+1.
- UDP byte k appears at T+21+k. The last byte appears at T+ip_packet_length; ip_data_out_valid is 0 at T+ip_packet_length+1.
- ip_data_out_valid is high continuously for exactly ip_packet_length cycles.
- mac_send_request deasserts in the same cycle as ip_data_out_valid.

## Test plan
- Reference packet:
  - Stimulus: LOCAL_IP C0A8010A, dest_ip C0A80164, udp_packet_length 26, ident 0.
  - Required: header 45 00 00 2E 00 00 40 00 80 11 77 00 C0 A8 01 0A C0 A8 01 64; 26 UDP bytes follow unmodified; 46 valid cycles total.
- Back-to-back packets:
  - Stimulus: two identical requests.
  - Required: ident bytes 00 00 then 00 01; second checksum 0x76FF.
- MAC backpressure:
  - Stimulus: mac_send_ready held low for 10 cycles.
  - Required: ip_send_ready stays 0 and no output until mac_send_ready rises; then the normal sequence.
- Request while busy:
  - Stimulus: udp_send_request pulsed during SEND_PAYLOAD.
  - Required: ignored; no second packet emitted.
- Early valid drop:
  - Stimulus: udp_packet_length 12; upstream valid for only 8 bytes.
  - Required: 32 output bytes; last 4 are 00.
- Reset mid-payload:
  - Stimulus: rstn low for 1 cycle during SEND_PAYLOAD.
  - Required: all outputs 0 on the next edge; state IDLE; next packet ident 00 00.
